dcache_ctrl_fsm: RTL
====================

// Module: dcache_ctrl_fsm
// PURPOSE
//  Parametrised D-cache controller FSM: drives tag/data array strobes, burst refill, dirty-line
//  write-back and uncached accesses. Sits between the MEM-stage request (load/store/uncached)
//  and the AXI-side memory bridge; supports write-back/write-allocate or write-through/no-allocate.
// PARAMETERS
//  LINE_WORDS  4  words per cache line = burst beats per refill/write-back; power of two, >=1
//  WRITE_BACK  1  1: write-back + write-allocate; 0: write-through + no-write-allocate
//  CNT_W       derived localparam = max(1,$clog2(LINE_WORDS)); beat counter width
// PORTS
//  clk           in   1      clock, all state on posedge
//  rst           in   1      synchronous, active-high reset
//  req_valid     in   1      MEM-stage request present; sampled only in IDLE
//  req_op        in   2      01 load, 10 store; 00/11 = no request (ignored)
//  req_uncached  in   1      bypass cache (MMIO)
//  hit           in   1      tag compare result, valid in LOOKUP
//  victim_dirty  in   1      selected victim way dirty, valid in LOOKUP
//  mem_ready     in   1      memory accepts/returns one beat this cycle
//  rbuf_we       out  1      latch request into request buffer
//  tag_rd_en     out  1      read tag/data arrays
//  cache_we      out  1      write store word into data array
//  dirty_set     out  1      mark line dirty
//  dirty_clr     out  1      clear line dirty (write-back finished)
//  refill_we     out  1      write returned beat into data array
//  beat_idx      out  CNT_W  word index for refill_we / write-back read
//  ret_we        out  1      latch uncached load data
//  data_from_mem out  1      forward refilled word to pipeline (load miss)
//  mem_valid     out  1      memory request active
//  mem_we        out  1      memory request is a write
//  mem_len       out  8      beats-1 (LINE_WORDS-1 for line ops, 0 single-word)
//  mem_uncached  out  1      single-word uncached/write-through access
//  pipeline_ready out 1      request complete; pipeline may advance this cycle
//  busy          out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0; while IDLE with no request every output is 0. rst mid-burst
//    abandons transaction, no further mem_valid; bridge is reset by same rst.
//  - Outputs are combinational from state/cnt/inputs; only state, cnt, op/uncached copies registered.
//  - IDLE: req_valid & op in{01,10}: rbuf_we=1, latch op; uncached -> UNC; else tag_rd_en=1 -> LOOKUP.
//    Requests arriving while busy are ignored (pipeline is stalled, holds them).
//  - LOOKUP: hit&load: pipeline_ready -> IDLE (2-cycle hit latency).
//    hit&store: cache_we; WRITE_BACK=1: dirty_set, pipeline_ready -> IDLE; =0: -> WT.
//    miss&store&WRITE_BACK=0 -> WT. other miss: victim_dirty&WRITE_BACK -> WB, else -> REFILL; cnt=0.
//  - WB: mem_valid, mem_we, mem_len=LINE_WORDS-1, beat_idx=cnt; cnt++ per mem_ready;
//    mem_ready at cnt==LINE_WORDS-1: dirty_clr, cnt=0 -> REFILL.
//  - REFILL: mem_valid, mem_we=0, mem_len=LINE_WORDS-1; refill_we=mem_ready, beat_idx=cnt;
//    last beat -> FINISH, cnt=0 (cnt wraps to 0, never exceeds LINE_WORDS-1).
//  - FINISH: load: data_from_mem, pipeline_ready; store: cache_we, dirty_set, pipeline_ready -> IDLE.
//  - UNC / WT: mem_valid, mem_uncached, mem_len=0, mem_we=(op==store); on mem_ready:
//    load: ret_we; pipeline_ready -> IDLE. Stall indefinitely while mem_ready=0.
//  - mem_valid, once raised, stays high until the final beat's mem_ready (no drop mid-burst).
//  - LINE_WORDS=1: each burst is one beat, beat_idx constant 0.
//  - Exactly one pipeline_ready pulse per accepted request; none for op 00/11.
// TESTING
//  1 load hit: req op=01, hit=1 -> rbuf_we,tag_rd_en cyc0; pipeline_ready cyc1; busy low cyc2.
//  2 store miss dirty, LINE_WORDS=4: 4 WB beats (beat_idx 0..3, mem_we=1), dirty_clr, 4 refill
//    beats refill_we, then cache_we+dirty_set+pipeline_ready in FINISH.
//  3 load miss clean, mem_ready every other cycle: mem_valid steady 8 cycles, 4 refill_we,
//    data_from_mem+pipeline_ready once.
//  4 uncached store, mem_ready delayed 5 cycles: mem_uncached,mem_we,mem_len=0 held; one pipeline_ready.
//  5 WRITE_BACK=0 store hit: cache_we in LOOKUP, no dirty_set, single-word write in WT.
//  6 rst asserted at refill beat 2 -> next cycle IDLE, all outputs 0; new load then completes normally.

Source files
------------

// File: rtl/dcache_ctrl_if.sv
// D-cache controller bundle: MEM-stage request, tag-compare results,
// array strobes and the single-channel memory bridge handshake.
interface dcache_ctrl_if #(
   parameter int CNT_W = 2
);
   // request side (MEM stage)
   logic             req_valid;
   logic [1:0]       req_op;
   logic             req_uncached;
   // tag compare results
   logic             hit;
   logic             victim_dirty;
   // memory bridge handshake
   logic             mem_ready;
   // array strobes
   logic             rbuf_we;
   logic             tag_rd_en;
   logic             cache_we;
   logic             dirty_set;
   logic             dirty_clr;
   logic             refill_we;
   logic [CNT_W-1:0] beat_idx;
   logic             ret_we;
   logic             data_from_mem;
   // memory request
   logic             mem_valid;
   logic             mem_we;
   logic [7:0]       mem_len;
   logic             mem_uncached;
   // pipeline status
   logic             pipeline_ready;
   logic             busy;

   // controller side
   modport master (
      input  req_valid, req_op, req_uncached, hit, victim_dirty, mem_ready,
      output rbuf_we, tag_rd_en, cache_we, dirty_set, dirty_clr, refill_we,
             beat_idx, ret_we, data_from_mem, mem_valid, mem_we, mem_len,
             mem_uncached, pipeline_ready, busy
   );

   // pipeline / memory / array side
   modport slave (
      output req_valid, req_op, req_uncached, hit, victim_dirty, mem_ready,
      input  rbuf_we, tag_rd_en, cache_we, dirty_set, dirty_clr, refill_we,
             beat_idx, ret_we, data_from_mem, mem_valid, mem_we, mem_len,
             mem_uncached, pipeline_ready, busy
   );
endinterface

// File: rtl/dcache_ctrl_fsm.sv
// D-cache controller FSM: lookup, dirty-line write-back, burst refill and
// single-word uncached / write-through accesses. Outputs are combinational
// from state, beat counter, latched op and live inputs.
module dcache_ctrl_fsm #(
   parameter int LINE_WORDS = 4,
   parameter int WRITE_BACK = 1
) (
   input  logic           clk,
   input  logic           rst,
   dcache_ctrl_if.master  bus
);
   localparam int             CNT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
   localparam logic [7:0]     LINE_LEN = 8'(LINE_WORDS - 1);
   localparam bit             WB_MODE  = (WRITE_BACK != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_WB     = 3'd2,
      S_REFILL = 3'd3,
      S_FINISH = 3'd4,
      S_UNC    = 3'd5,
      S_WT     = 3'd6
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             store_reg, store_next;

   logic req_ok;
   logic req_store;
   logic last_beat;

   // only load (01) and store (10) are real requests
   assign req_ok    = bus.req_valid & ((bus.req_op == 2'b01) | (bus.req_op == 2'b10));
   assign req_store = (bus.req_op == 2'b10);
   assign last_beat = (cnt_reg == CNT_LAST);

   // state, beat counter and latched op; reset abandons any transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         store_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         store_reg <= store_next;
      end
   end

   // next-state and beat counter sequencing
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      store_next = store_reg;
      case (state_reg)
         S_IDLE: begin
            cnt_next = '0;
            if (req_ok) begin
               store_next = req_store;
               state_next = bus.req_uncached ? S_UNC : S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            cnt_next = '0;
            if (bus.hit) begin
               // write-through store hits still need the memory write
               state_next = (store_reg && !WB_MODE) ? S_WT : S_IDLE;
            end else if (store_reg && !WB_MODE) begin
               state_next = S_WT;
            end else if (bus.victim_dirty && WB_MODE) begin
               state_next = S_WB;
            end else begin
               state_next = S_REFILL;
            end
         end
         S_WB: begin
            if (bus.mem_ready) begin
               if (last_beat) begin
                  cnt_next   = '0;
                  state_next = S_REFILL;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         S_REFILL: begin
            if (bus.mem_ready) begin
               if (last_beat) begin
                  cnt_next   = '0;
                  state_next = S_FINISH;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
         end
         S_UNC, S_WT: begin
            if (bus.mem_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // strobes and memory request decode
   always_comb begin
      bus.rbuf_we        = 1'b0;
      bus.tag_rd_en      = 1'b0;
      bus.cache_we       = 1'b0;
      bus.dirty_set      = 1'b0;
      bus.dirty_clr      = 1'b0;
      bus.refill_we      = 1'b0;
      bus.beat_idx       = cnt_reg;
      bus.ret_we         = 1'b0;
      bus.data_from_mem  = 1'b0;
      bus.mem_valid      = 1'b0;
      bus.mem_we         = 1'b0;
      bus.mem_len        = 8'd0;
      bus.mem_uncached   = 1'b0;
      bus.pipeline_ready = 1'b0;
      bus.busy           = (state_reg != S_IDLE);
      case (state_reg)
         S_IDLE: begin
            if (req_ok) begin
               bus.rbuf_we   = 1'b1;
               bus.tag_rd_en = !bus.req_uncached;
            end
         end
         S_LOOKUP: begin
            if (bus.hit) begin
               if (!store_reg) begin
                  bus.pipeline_ready = 1'b1;
               end else begin
                  bus.cache_we = 1'b1;
                  if (WB_MODE) begin
                     bus.dirty_set      = 1'b1;
                     bus.pipeline_ready = 1'b1;
                  end
               end
            end
         end
         S_WB: begin
            bus.mem_valid = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_len   = LINE_LEN;
            bus.dirty_clr = bus.mem_ready & last_beat;
         end
         S_REFILL: begin
            bus.mem_valid = 1'b1;
            bus.mem_len   = LINE_LEN;
            bus.refill_we = bus.mem_ready;
         end
         S_FINISH: begin
            bus.pipeline_ready = 1'b1;
            if (store_reg) begin
               bus.cache_we  = 1'b1;
               bus.dirty_set = 1'b1;
            end else begin
               bus.data_from_mem = 1'b1;
            end
         end
         S_UNC, S_WT: begin
            bus.mem_valid      = 1'b1;
            bus.mem_uncached   = 1'b1;
            bus.mem_we         = store_reg;
            bus.ret_we         = bus.mem_ready & !store_reg;
            bus.pipeline_ready = bus.mem_ready;
         end
         default: begin
            bus.busy = 1'b1;
         end
      endcase
   end
endmodule
